// File: rtl/pc_pkg.sv
// Shared constants for the fetch-stage program-counter unit.
package pc_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_BOOT = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_HALT = 2'd2;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_if.sv
// Redirect/control inputs and fetch-address outputs of the PC unit.
interface pc_unit_if #(parameter int ADDR_W = 32);
  import pc_pkg::*;

  logic              stall;
  logic              exc;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              call;
  logic              ret;
  logic              halt;
  logic              wake;

  logic [ADDR_W-1:0]  pc;
  logic               pc_valid;
  logic [ADDR_W-1:0]  epc;
  logic [STATE_W-1:0] state;
  logic               ras_empty;
  logic               ras_full;

  modport master (
    output stall, exc, br_taken, br_target, jump, jump_target, call, ret, halt, wake,
    input  pc, pc_valid, epc, state, ras_empty, ras_full
  );

  modport slave (
    input  stall, exc, br_taken, br_target, jump, jump_target, call, ret, halt, wake,
    output pc, pc_valid, epc, state, ras_empty, ras_full
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     count;

  // ptr is the next write slot, so the live top sits one below it
  assign top   = mem[ptr - PTR_ONE];
  assign empty = (count == '0);
  assign full  = (count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr      <= ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot/run/halt sequencing, prioritised redirects, RAS.
//   state   | meaning
//   BOOT    | one cycle after reset, fetch not yet valid
//   RUN     | fetching; redirect priority exc > stall > ret > branch > jump > halt > seq
//   HALT    | pc held, fetch invalid until exc or wake
//   (3)     | unreachable, treated as BOOT
module pc_unit import pc_pkg::*; #(
  parameter int              ADDR_W       = 32,
  parameter int              INC          = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic      clk,
  input  logic      reset,
  pc_unit_if.slave  bus
);

  localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INC - 1);

  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;
  logic [ADDR_W-1:0]  epc_q;
  logic [STATE_W-1:0] state_q;

  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_push;
  logic              ras_pop;
  logic              run_go;

  assign pc_seq = pc_q + INC_V;

  // RAS only moves in RUN when neither exc nor stall claims the cycle
  always_comb begin
    run_go   = (state_q == ST_RUN) && !bus.exc && !bus.stall;
    ras_pop  = run_go && bus.ret && !ras_empty;
    ras_push = run_go && !ras_pop && !bus.br_taken && bus.jump && bus.call;
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      epc_q   <= '0;
      state_q <= ST_BOOT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.exc) begin
            epc_q   <= pc_q;
            pc_q    <= EXC_VECTOR & ALIGN_MASK;
            valid_q <= 1'b1;
          end else if (bus.stall) begin
            pc_q <= pc_q;
          end else if (bus.ret && !ras_empty) begin
            pc_q <= ras_top & ALIGN_MASK;
          end else if (bus.br_taken) begin
            pc_q <= bus.br_target & ALIGN_MASK;
          end else if (bus.jump) begin
            pc_q <= bus.jump_target & ALIGN_MASK;
          end else if (bus.halt) begin
            state_q <= ST_HALT;
            valid_q <= 1'b0;
          end else begin
            pc_q <= pc_seq;
          end
        end
        ST_HALT: begin
          if (bus.exc) begin
            epc_q   <= pc_q;
            pc_q    <= EXC_VECTOR & ALIGN_MASK;
            state_q <= ST_RUN;
            valid_q <= 1'b1;
          end else if (bus.wake) begin
            pc_q    <= pc_seq;
            state_q <= ST_RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          valid_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_valid  = valid_q;
  assign bus.epc       = epc_q;
  assign bus.state     = state_q;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the MIPS fetch stage. Supersedes the plain PC register.
- Adds boot sequencing, stall hold, priority next-PC selection (exception, return, branch, jump, sequential) and halt/wake control.
- Includes a small circular return-address stack (RAS) for call/return redirection, and captures the exception PC.
- Feeds instruction memory address and fetch-valid to the IF stage.

Parameters:
ADDR_W, 32, PC width in bits
INC, 4, sequential increment in bytes (power of two)
RESET_VECTOR, 32'h0000_0000, PC after reset
EXC_VECTOR, 32'h0000_0080, PC loaded on exception
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold PC and RAS this cycle
exc  in  1  exception request
br_taken  in  1  conditional branch resolved taken
br_target  in  ADDR_W  branch target
jump  in  1  unconditional jump
jump_target  in  ADDR_W  jump target
call  in  1  qualifies jump as call (push return address)
ret  in  1  return, redirect to RAS top
halt  in  1  enter HALT
wake  in  1  leave HALT
pc  out  ADDR_W  current fetch address (registered)
pc_valid  out  1  fetch address valid (registered)
epc  out  ADDR_W  PC captured at last exception
state  out  2  BOOT=0, RUN=1, HALT=2
ras_empty  out  1  RAS holds no entries
ras_full  out  1  RAS holds RAS_DEPTH entries

Behaviour:
- Reset (sync, any state, overrides all inputs):
  - pc=RESET_VECTOR, pc_valid=0, epc=0, state=BOOT.
  - RAS count=0, ptr=0, so ras_empty=1 and ras_full=0.
- BOOT: lasts exactly one cycle. Next edge: state=RUN, pc_valid=1, pc unchanged. exc during BOOT is ignored.
- RUN: per-edge priority, first match wins:
  1. exc: epc<=pc, pc<=EXC_VECTOR, pc_valid=1. RAS untouched. Stall is ignored.
  2. stall: pc, RAS and state all hold.
  3. ret and RAS not empty: pc<=top entry, pop (count-1). call in the same cycle is ignored. ret with RAS empty falls through to the next priority.
  4. br_taken: pc<=br_target.
  5. jump: pc<=jump_target. If call is also high, push pc+INC.
  6. halt: state<=HALT, pc holds, pc_valid<=0.
  7. Otherwise: pc<=pc+INC.
- call without jump has no effect.
- HALT:
  - pc holds, pc_valid=0.
  - exc: same action as in RUN; state<=RUN, pc_valid=1.
  - wake (without exc): state<=RUN, pc<=pc+INC, pc_valid=1.
  - stall, branch, jump and ret are ignored.
- Arithmetic: pc+INC wraps modulo 2^ADDR_W. All loaded targets have their low log2(INC) bits forced to 0.
- RAS:
  - Circular, ptr indexes the next write slot; top is entry ptr-1.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop decrements ptr and count.
  - ras_empty and ras_full are combinational from count.
- State value 3 is unreachable; decode it as BOOT.
- Single-cycle latency: every redirect takes effect on the edge where it is sampled. No internal bubbles apart from BOOT and HALT.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding constants (ST_BOOT, ST_RUN, ST_HALT);
  - default vector constants (RESET_VECTOR, EXC_VECTOR).
- One sub-module is natural: ras_stack, parametrised by ADDR_W and RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full.
  - Its reset is synchronous like the parent's.
- Next-PC priority mux and FSM stay in pc_unit.

Test Plan:
- Reset then idle: after reset pc=0 and pc_valid=0 for 1 cycle; then pc_valid=1 and pc steps 0, 4, 8, 12 on successive edges.
- Stall and branch: stall high for 3 cycles at pc=0x10, pc holds 0x10; then br_taken with br_target=0x43 gives pc=0x40; br_taken together with jump(0x100) gives branch target only.
- Call/return: jump+call to 0x200 at pc=0x20, then ret gives pc=0x24 and ras_empty=1; a further ret gives pc+4.
- RAS overflow: 5 calls with RAS_DEPTH=4 from pcs 0x0, 0x100, 0x200, 0x300, 0x400 gives ras_full=1. Four rets return 0x404, 0x304, 0x204, 0x104, then ras_empty=1.
- Exception: exc together with stall at pc=0x58 gives epc=0x58 and pc=0x80. exc while in HALT gives state=RUN, pc=0x80, pc_valid=1.
- Halt/wake and wrap: halt at pc=0x30 gives pc_valid=0 with pc held; wake gives pc=0x34. Separately, sequential increment from pc=0xFFFF_FFFC gives pc=0. Reset asserted while in HALT returns to BOOT with pc=RESET_VECTOR.
